// File: rtl/timing_sequencer.sv
// ---------------------------------------------------------------------------
// timing_sequencer
//
// Generates the 4004 machine-cycle timing from the fast system clock. A free
// running divider (div_cnt) splits every 4004 clock period into CLK_DIV
// sysclk cycles. Two one-sysclk-wide strobes are issued per period:
// clk1 when the divider wraps to 0, and clk2 half a period later. The eight
// subcycles A1 A2 A3 M1 M2 X1 X2 X3 advance on every clk1. The last sysclk
// of X3 is the machine-cycle boundary, where a halt request can freeze the
// machine in X3. While frozen the divider keeps running, so a resume is
// always aligned to the divider phase.
//
// Parameters:
//   CLK_DIV   sysclk cycles per 4004 clock period (even, >= 4)
//
// Configuration macro:
//   SINGLE_STEP_EN  adds step_req; a pulse while halted runs exactly one
//                   machine cycle at the next boundary, whatever halt_req is.
//
// Ports:
//   sysclk    in   system clock, everything on posedge
//   reset_n   in   synchronous reset, active low
//   halt_req  in   level request to stop at the next machine-cycle boundary
//   step_req  in   single machine-cycle run pulse while halted (SINGLE_STEP_EN)
//   clk1      out  phase-1 strobe, one sysclk wide
//   clk2      out  phase-2 strobe, one sysclk wide
//   state     out  subcycle number, 0=A1 .. 7=X3
//   state_oh  out  one-hot copy of state
//   sync      out  high in X3 while running
//   halted    out  machine frozen in X3, no strobes issued
// ---------------------------------------------------------------------------
module timing_sequencer #(
   parameter int CLK_DIV = 8
) (
   input  logic       sysclk,
   input  logic       reset_n,
   input  logic       halt_req,
`ifdef SINGLE_STEP_EN
   input  logic       step_req,
`endif
   output logic       clk1,
   output logic       clk2,
   output logic [2:0] state,
   output logic [7:0] state_oh,
   output logic       sync,
   output logic       halted
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   typedef enum logic [2:0] {
      A1 = 3'd0,
      A2 = 3'd1,
      A3 = 3'd2,
      M1 = 3'd3,
      M2 = 3'd4,
      X1 = 3'd5,
      X2 = 3'd6,
      X3 = 3'd7
   } subcycle_t;

   subcycle_t        state_q;
   subcycle_t        state_n;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_n;
   logic             halted_n;
   logic             clk1_n;
   logic             clk2_n;
   logic             sync_n;
   logic [7:0]       oh_n;
   logic             halt_obeyed;
   logic             fresh;
`ifdef SINGLE_STEP_EN
   logic             step_pending;
   logic             step_pending_n;
`endif

   // Next-state logic. The reset state sits in X3 with the divider at its
   // last count, which looks exactly like a boundary; "fresh" marks that
   // first cycle so the machine always starts with clk1 in A1 instead of
   // honouring halt_req there. Once halted the machine is parked in X3, so
   // every divider wrap is a boundary sample.
   always_comb begin
      div_n    = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      state_n  = state_q;
      halted_n = halted;
      clk1_n   = 1'b0;
`ifdef SINGLE_STEP_EN
      step_pending_n = step_pending || (halted && step_req);
      halt_obeyed    = halt_req && !(halted && (step_pending || step_req));
`else
      halt_obeyed    = halt_req;
`endif
      if (div_cnt == DIV_LAST) begin
         if (fresh) begin
            state_n  = A1;
            clk1_n   = 1'b1;
            halted_n = 1'b0;
         end else if (state_q == X3) begin
            if (halt_obeyed) begin
               halted_n = 1'b1;
            end else begin
               halted_n = 1'b0;
               clk1_n   = 1'b1;
               state_n  = A1;
`ifdef SINGLE_STEP_EN
               step_pending_n = 1'b0;
`endif
            end
         end else if (!halted) begin
            state_n = subcycle_t'(state_q + 3'd1);
            clk1_n  = 1'b1;
         end
      end
      clk2_n = (div_n == DIV_HALF) && !halted_n;
      sync_n = (state_n == X3) && !halted_n;
      oh_n   = 8'b1 << state_n;
   end

   // All outputs are registered from the next-state values above, so
   // state_oh and sync always agree with state/halted in the same cycle.
   always_ff @(posedge sysclk) begin
      if (!reset_n) begin
         div_cnt      <= DIV_LAST;
         state_q      <= X3;
         halted       <= 1'b0;
         clk1         <= 1'b0;
         clk2         <= 1'b0;
         sync         <= 1'b1;
         state_oh     <= 8'h80;
         fresh        <= 1'b1;
`ifdef SINGLE_STEP_EN
         step_pending <= 1'b0;
`endif
      end else begin
         div_cnt      <= div_n;
         state_q      <= state_n;
         halted       <= halted_n;
         clk1         <= clk1_n;
         clk2         <= clk2_n;
         sync         <= sync_n;
         state_oh     <= oh_n;
         fresh        <= 1'b0;
`ifdef SINGLE_STEP_EN
         step_pending <= step_pending_n;
`endif
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// ---------------------------------------------------------------------------
// tb_timing_sequencer
//
// Self-checking bench for timing_sequencer. A reference model describes the
// timing in terms of "sysclk cycles since the machine last started running"
// and derives subcycle and strobes arithmetically from that count. Directed
// checkpoints come from a table of expected outputs at given cycle numbers,
// followed by hand-written halt/reset/step sequences and a randomized run.
// Build with SINGLE_STEP_EN defined to include the single-step sequences.
// ---------------------------------------------------------------------------
module tb_timing_sequencer;

   localparam int CLK_DIV = 8;
   localparam int MC      = 8 * CLK_DIV;
`ifdef SINGLE_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic       sysclk   = 1'b0;
   logic       reset_n  = 1'b0;
   logic       halt_req = 1'b0;
   logic       step_req = 1'b0;
   logic       clk1;
   logic       clk2;
   logic [2:0] state;
   logic [7:0] state_oh;
   logic       sync;
   logic       halted;

   always #5 sysclk = ~sysclk;

   timing_sequencer #(.CLK_DIV(CLK_DIV)) dut (
      .sysclk   (sysclk),
      .reset_n  (reset_n),
      .halt_req (halt_req),
`ifdef SINGLE_STEP_EN
      .step_req (step_req),
`endif
      .clk1     (clk1),
      .clk2     (clk2),
      .state    (state),
      .state_oh (state_oh),
      .sync     (sync),
      .halted   (halted)
   );

   int vectors     = 0;
   int miscompares = 0;
   int t           = -1;

   // Reference model state: in reset, halted, or running for m_elapsed
   // sysclk cycles since the last start. m_div is the free-running phase.
   bit m_inreset = 1'b1;
   bit m_halted  = 1'b0;
   bit m_pending = 1'b0;
   int m_div     = CLK_DIV - 1;
   int m_elapsed = 0;

   logic       e_clk1;
   logic       e_clk2;
   logic [2:0] e_state;
   logic [7:0] e_oh;
   logic       e_sync;
   logic       e_halted;

   typedef struct {
      bit         rst;
      int         t;
      logic       hr;
      logic       c1;
      logic       c2;
      logic [2:0] st;
      logic [7:0] oh;
      logic       sy;
      logic       hl;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, int tt, logic hr, logic c1, logic c2,
                               logic [2:0] st, logic sy, logic hl);
      vec_t v;
      v.rst = rst;
      v.t   = tt;
      v.hr  = hr;
      v.c1  = c1;
      v.c2  = c2;
      v.st  = st;
      v.oh  = 8'h01 << st;
      v.sy  = sy;
      v.hl  = hl;
      return v;
   endfunction

   // Advances the model over one posedge using the inputs present at it.
   task automatic modelStep();
      int st;
      if (!reset_n) begin
         m_inreset = 1'b1;
         m_halted  = 1'b0;
         m_pending = 1'b0;
         m_div     = CLK_DIV - 1;
      end else if (m_inreset) begin
         m_inreset = 1'b0;
         m_halted  = 1'b0;
         m_elapsed = 0;
         m_div     = 0;
      end else begin
         if (!m_halted) begin
            if ((m_elapsed % MC) == MC - 1 && halt_req)
               m_halted = 1'b1;
            else
               m_elapsed++;
         end else begin
            if (STEP_EN && step_req)
               m_pending = 1'b1;
            if (m_div == CLK_DIV - 1 && (!halt_req || m_pending)) begin
               m_halted  = 1'b0;
               m_elapsed = 0;
               m_pending = 1'b0;
            end
         end
         m_div = (m_div + 1) % CLK_DIV;
      end
      if (m_inreset) begin
         e_clk1 = 0; e_clk2 = 0; e_state = 3'd7; e_sync = 1; e_halted = 0;
      end else if (m_halted) begin
         e_clk1 = 0; e_clk2 = 0; e_state = 3'd7; e_sync = 0; e_halted = 1;
      end else begin
         st       = (m_elapsed / CLK_DIV) % 8;
         e_state  = 3'(st);
         e_clk1   = (m_elapsed % CLK_DIV) == 0;
         e_clk2   = (m_elapsed % CLK_DIV) == CLK_DIV / 2;
         e_sync   = (st == 7);
         e_halted = 1'b0;
      end
      e_oh = 8'h01 << e_state;
   endtask

   task automatic checkOutput(string name, logic c1, logic c2, logic [2:0] st,
                              logic [7:0] oh, logic sy, logic hl);
      vectors++;
      if ({clk1, clk2, state, state_oh, sync, halted} !== {c1, c2, st, oh, sy, hl}) begin
         miscompares++;
         $display("[TB] FAIL %s t=%0d got clk1=%b clk2=%b state=%0d oh=%h sync=%b halted=%b expected clk1=%b clk2=%b state=%0d oh=%h sync=%b halted=%b",
                  name, t, clk1, clk2, state, state_oh, sync, halted, c1, c2, st, oh, sy, hl);
      end
   endtask

   task automatic checkCount(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s t=%0d got %0d expected %0d", name, t, act, exp);
      end
   endtask

   // Drives one cycle of inputs, clocks it, and compares against the model.
   task automatic applyStimulus(logic rn, logic hr, logic sr);
      @(negedge sysclk);
      reset_n  = rn;
      halt_req = hr;
      step_req = sr;
      @(posedge sysclk);
      modelStep();
      if (!rn) t = -1;
      else     t++;
      #1;
      checkOutput("model", e_clk1, e_clk2, e_state, e_oh, e_sync, e_halted);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   // Holds halt_req high until the machine freezes, bounded.
   task automatic haltNow(string name);
      int n = 0;
      while (!halted && n < MC + 2) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         n++;
      end
      checkCount({name, " halt reached"}, int'(halted), 1);
   endtask

   task automatic runStep(string name, int pulses);
      int c1 = 0;
      int c2 = 0;
      bit ran = 0;
      bit done = 0;
      for (int p = 0; p < pulses; p++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         if (clk1) c1++;
         if (clk2) c2++;
         if (!halted) ran = 1;
      end
      for (int i = 0; i < 3 * MC && !done; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (clk1) c1++;
         if (clk2) c2++;
         if (!halted) ran = 1;
         else if (ran) done = 1;
      end
      checkCount({name, " clk1 pulses"}, c1, 8);
      checkCount({name, " clk2 pulses"}, c2, 8);
      checkCount({name, " re-halted"}, int'(done), 1);
      checkCount({name, " state"}, int'(state), 7);
   endtask

   initial begin
      int q;
      bit found;
      logic hr;
      int hold;

      $display("[TB] timing_sequencer bench, CLK_DIV=%0d, step=%0d", CLK_DIV, STEP_EN);

      // Free-running timing over three machine cycles.
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,   0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0,   4, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0,   8, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0,  12, 0, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0,  27, 0, 0, 0, 3, 0, 0));
      tbl.push_back(mk(0,  55, 0, 0, 0, 6, 0, 0));
      tbl.push_back(mk(0,  56, 0, 1, 0, 7, 1, 0));
      tbl.push_back(mk(0,  60, 0, 0, 1, 7, 1, 0));
      tbl.push_back(mk(0,  63, 0, 0, 0, 7, 1, 0));
      tbl.push_back(mk(0,  64, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0,  68, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 124, 0, 0, 1, 7, 1, 0));
      tbl.push_back(mk(0, 128, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 191, 0, 0, 0, 7, 1, 0));
      // halt_req only during X1: ignored.
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,  40, 0, 1, 0, 5, 0, 0));
      tbl.push_back(mk(0,  48, 1, 1, 0, 6, 0, 0));
      tbl.push_back(mk(0,  64, 0, 1, 0, 0, 0, 0));
      // halt_req raised in M1, dropped at t=170.
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0,  24, 0, 1, 0, 3, 0, 0));
      tbl.push_back(mk(0,  63, 1, 0, 0, 7, 1, 0));
      tbl.push_back(mk(0,  64, 1, 0, 0, 7, 0, 1));
      tbl.push_back(mk(0,  68, 1, 0, 0, 7, 0, 1));
      tbl.push_back(mk(0,  72, 1, 0, 0, 7, 0, 1));
      tbl.push_back(mk(0, 170, 1, 0, 0, 7, 0, 1));
      tbl.push_back(mk(0, 175, 0, 0, 0, 7, 0, 1));
      tbl.push_back(mk(0, 176, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 180, 0, 0, 1, 0, 0, 0));

      doReset();
      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            doReset();
            checkOutput($sformatf("table[%0d] reset", i), 0, 0, 3'd7, 8'h80, 1, 0);
         end else begin
            while (t < tbl[i].t) applyStimulus(1'b1, tbl[i].hr, 1'b0);
            checkOutput($sformatf("table[%0d] t=%0d", i, tbl[i].t),
                        tbl[i].c1, tbl[i].c2, tbl[i].st, tbl[i].oh, tbl[i].sy, tbl[i].hl);
         end
      end

      // No strobes at all while halted, then a phase-aligned resume.
      doReset();
      haltNow("quiet");
      q = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (clk1 || clk2) q++;
      end
      checkCount("strobes while halted", q, 0);
      found = 0;
      for (int i = 0; i < CLK_DIV + 1 && !found; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (clk1) found = 1;
      end
      checkCount("resume clk1 seen", int'(found), 1);
      checkCount("resume state", int'(state), 0);

      // Reset in M2 while running.
      doReset();
      while (t < 36) applyStimulus(1'b1, 1'b0, 1'b0);
      checkCount("before reset in M2", int'(state), 4);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("reset in M2", 0, 0, 3'd7, 8'h80, 1, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("release after M2 reset", 1, 0, 3'd0, 8'h01, 0, 0);

      // Reset while halted clears the halt even with halt_req still high.
      haltNow("pre-reset");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("reset while halted", 0, 0, 3'd7, 8'h80, 1, 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("release with halt_req", 1, 0, 3'd0, 8'h01, 0, 0);

`ifdef SINGLE_STEP_EN
      doReset();
      haltNow("step");
      runStep("step 1", 1);
      runStep("step 2", 1);
      runStep("step 3", 1);
      runStep("double pulse", 2);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      checkCount("no spurious step", int'(halted), 1);
`endif

      // Randomized run against the model.
      doReset();
      hr   = 1'b0;
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            hr   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 150);
         end
         hold--;
         applyStimulus(logic'($urandom_range(0, 499) != 0), hr,
                       logic'($urandom_range(0, 39) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
